// File: rtl/sbox_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine: LANES independent bytes per beat,
// forward or inverse S-box chosen per beat, PIPE_STAGES cycles of latency with valid/ready flow control.
module sbox_pipe #(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] dout,
  output logic               busy
);

  if (LANES < 1 || LANES > 16) begin : gBadLanes
    $error("sbox_pipe: LANES must be in 1..16");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : gBadStages
    $error("sbox_pipe: PIPE_STAGES must be in 1..3");
  end

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and naturally maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affFwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affInv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [8*LANES-1:0] finishBus(input logic [8*LANES-1:0] x, input logic inv);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = inv ? x[8*l +: 8] : affFwd(x[8*l +: 8]);
    return r;
  endfunction

  logic                     w_adv;
  logic [8*LANES-1:0]       w_x;
  logic [PIPE_STAGES-1:0]   r_valid;
  logic [8*LANES-1:0]       r_data [PIPE_STAGES];

  // One shared inverter per lane; the inverse affine step is folded in ahead of it
  always_comb begin
    w_x = '0;
    for (int l = 0; l < LANES; l++)
      w_x[8*l +: 8] = gfInv(in_inv ? affInv(din[8*l +: 8]) : din[8*l +: 8]);
  end

  assign w_adv     = out_ready || !out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[PIPE_STAGES-1];
  assign dout      = r_data[PIPE_STAGES-1];
  assign busy      = |r_valid;

  if (PIPE_STAGES == 1) begin : gOne
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid   <= '0;
        r_data[0] <= '0;
      end else if (w_adv) begin
        r_valid[0] <= in_valid;
        r_data[0]  <= finishBus(w_x, in_inv);
      end
    end
  end else begin : gMulti
    // Stage 0 holds the inverted bytes; the forward affine is applied entering stage 1
    logic r_inv0;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= '0;
        r_inv0  <= 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) r_data[s] <= '0;
      end else if (w_adv) begin
        r_valid   <= {r_valid[PIPE_STAGES-2:0], in_valid};
        r_inv0    <= in_inv;
        r_data[0] <= w_x;
        r_data[1] <= finishBus(r_data[0], r_inv0);
        for (int s = 2; s < PIPE_STAGES; s++) r_data[s] <= r_data[s-1];
      end
    end
  end

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: a 16-lane/2-stage instance plus 4-lane instances at 1, 2 and 3 stages,
// checked against FIPS-197 table lookups through transaction scoreboards.
module tb_sbox_pipe;

  localparam int P = 2;
  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vecT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, inValid, inInv, outReady;
  logic [127:0] din;
  logic         inReady, outValid, busy;
  logic [127:0] dout;
  logic         sInValid, sInInv, sOutReady;
  logic [31:0]  sDin;
  wire  [2:0]   sInReady, sOutValid, sBusy;
  wire  [95:0]  sDoutBus;

  logic [7:0]   sboxTab [256];
  logic [7:0]   invTab  [256];
  logic [127:0] expQ [$];
  logic [31:0]  sExp [3][4096];
  int           sWr [3];
  int           sRd [3];
  int           vecCount = 0;
  int           missCount = 0;
  vecT          tab [6];

  sbox_pipe #(.LANES(16), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_inv(inInv), .din(din),
    .out_valid(outValid), .out_ready(outReady), .dout(dout), .busy(busy));

  for (genvar k = 0; k < 3; k++) begin : gSmall
    sbox_pipe #(.LANES(4), .PIPE_STAGES(k+1)) dutSmall (
      .clk(clk), .rst(rst), .in_valid(sInValid), .in_ready(sInReady[k]), .in_inv(sInInv),
      .din(sDin), .out_valid(sOutValid[k]), .out_ready(sOutReady), .dout(sDoutBus[32*k +: 32]),
      .busy(sBusy[k]));
  end

  function automatic logic [127:0] model16(input logic [127:0] d, input logic inv);
    logic [127:0] m;
    for (int l = 0; l < 16; l++) m[8*l +: 8] = inv ? invTab[d[8*l +: 8]] : sboxTab[d[8*l +: 8]];
    return m;
  endfunction

  function automatic logic [31:0] model4(input logic [31:0] d, input logic inv);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = inv ? invTab[d[8*l +: 8]] : sboxTab[d[8*l +: 8]];
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic allDrained();
    return (expQ.size() == 0) && (sRd[0] == sWr[0]) && (sRd[1] == sWr[1]) && (sRd[2] == sWr[2]);
  endfunction

  // Scoreboards: record accepted beats, compare consumed beats in order; reset discards in-flight beats
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      for (int k = 0; k < 3; k++) sRd[k] = sWr[k];
    end else begin
      if (outValid && outReady) begin
        checkOutput("mainBeatExpected", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) checkOutput("mainDout", dout, expQ.pop_front());
      end
      if (inValid && inReady) expQ.push_back(model16(din, inInv));
      for (int k = 0; k < 3; k++) begin
        if (sOutValid[k] && sOutReady) begin
          checkOutput("smallBeatExpected", sRd[k] != sWr[k], 1'b1);
          if (sRd[k] != sWr[k]) begin
            checkOutput("smallDout", sDoutBus[32*k +: 32], sExp[k][sRd[k] % 4096]);
            sRd[k]++;
          end
        end
        if (sInValid && sInReady[k]) begin
          sExp[k][sWr[k] % 4096] = model4(sDin, sInInv);
          sWr[k]++;
        end
      end
    end
  end

  // One beat into every instance, then watch each output for exactly its own latency
  task automatic applyStimulus(input logic [127:0] d, input logic inv, input logic [127:0] exp);
    inValid = 1'b1; inInv = inv; din = d; outReady = 1'b1;
    sInValid = 1'b1; sInInv = inv; sDin = d[31:0]; sOutReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; sInValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checkOutput("latMainValid", outValid, c == P);
      if (c == P) checkOutput("tableDout", dout, exp);
      for (int k = 0; k < 3; k++) checkOutput("latSmallValid", sOutValid[k], c == k + 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    inValid = 1'b0; sInValid = 1'b0; outReady = 1'b1; sOutReady = 1'b1;
    while (!allDrained() && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, allDrained(), 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
    $finish;
  end

  initial begin
    logic [2047:0] hexAll;
    logic [127:0]  fwd [16];
    int firstV, lastV, nV;
    hexAll = SBOX_HEX;
    for (int i = 0; i < 256; i++) sboxTab[i] = hexAll[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) invTab[sboxTab[i]] = i[7:0];
    for (int k = 0; k < 3; k++) begin sWr[k] = 0; sRd[k] = 0; end

    tab[0] = '{128'h000000000000000000000000FF530100, 1'b0, 128'h63636363636363636363636316ED7C63};
    tab[1] = '{128'h63636363636363636363636316ED7C63, 1'b1, 128'h000000000000000000000000FF530100};
    tab[2] = '{128'h00102030405060708090a0b0c0d0e0f0, 1'b0, 128'h63cab7040953d051cd60e0e7ba70e18c};
    tab[3] = '{128'h63cab7040953d051cd60e0e7ba70e18c, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0};
    tab[4] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
    tab[5] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};

    // Reset held two cycles with traffic offered
    rst = 1'b1; inValid = 1'b1; inInv = 1'b0; din = {4{$urandom}}; outReady = 1'b1;
    sInValid = 1'b1; sInInv = 1'b0; sDin = $urandom; sOutReady = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #3;
      checkOutput("rstOutValid", outValid, 1'b0);
      checkOutput("rstDout", dout, '0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstSmallValid", sOutValid, 3'b000);
      checkOutput("rstSmallBusy", sBusy, 3'b000);
    end
    rst = 1'b0; inValid = 1'b0; sInValid = 1'b0;
    @(posedge clk); #3;
    checkOutput("postRstInReady", inReady, 1'b1);
    checkOutput("postRstSmallInReady", sInReady, 3'b111);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) applyStimulus(tab[i].din, tab[i].inv, tab[i].exp);

    // All 256 byte values forward, then back through the inverse
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 16; l++) din[8*l +: 8] = 8'(16*i + l);
      fwd[i] = model16(din, 1'b0);
      inValid = 1'b1; inInv = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) begin
      din = fwd[i]; inValid = 1'b1; inInv = 1'b1;
      @(posedge clk); #1;
    end
    waitDrain("roundTripDrain");

    // Eight back-to-back beats with alternating mode
    firstV = -1; lastV = -1; nV = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin inValid = 1'b1; inInv = c[0]; din = {$urandom, $urandom, $urandom, $urandom}; end
      else inValid = 1'b0;
      #2;
      if (c < 8) checkOutput("streamInReady", inReady, 1'b1);
      if (outValid) begin nV++; if (firstV < 0) firstV = c; lastV = c; end
      @(posedge clk); #1;
    end
    checkOutput("streamCount", nV, 8);
    checkOutput("streamFirst", firstV, P);
    checkOutput("streamRun", lastV - firstV, 7);
    waitDrain("streamDrain");

    // Five stalled cycles in the middle of a stream
    for (int c = 0; c < 16; c++) begin
      inValid = 1'b1; inInv = 1'($urandom); din = {$urandom, $urandom, $urandom, $urandom};
      outReady = !(c >= 6 && c <= 10);
      #2;
      if (!outReady) begin
        checkOutput("stallInReady", inReady, 1'b0);
        checkOutput("stallOutValid", outValid, 1'b1);
        checkOutput("stallHasBeat", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) checkOutput("stallDoutHeld", dout, expQ[0]);
      end
      @(posedge clk); #1;
    end
    waitDrain("stallDrain");

    // Reset with beats in flight, then a fresh beat must arrive after exactly the pipeline latency
    for (int c = 0; c < 2; c++) begin
      inValid = 1'b1; inInv = 1'b0; din = {$urandom, $urandom, $urandom, $urandom};
      sInValid = 1'b1; sInInv = 1'b1; sDin = $urandom;
      @(posedge clk); #1;
    end
    inValid = 1'b0; sInValid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checkOutput("midRstOutValid", outValid, 1'b0);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstSmallValid", sOutValid, 3'b000);
    @(posedge clk); #1;
    din = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(din, 1'b1, model16(din, 1'b1));

    // Randomised traffic and back-pressure on every instance
    for (int c = 0; c < 400; c++) begin
      inValid = ($urandom % 4) != 0; inInv = 1'($urandom); din = {$urandom, $urandom, $urandom, $urandom};
      outReady = ($urandom % 3) != 0;
      sInValid = ($urandom % 4) != 0; sInInv = 1'($urandom); sDin = $urandom;
      sOutReady = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    waitDrain("randomDrain");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
